// File: rtl/code_pkg.sv
// Shared definitions for the code sequence checker: state encoding, digit type
// and the code table shared with the display-side digit lookup.
package code_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam int SEQ_LEN_MAX = 15;

    // Entry 15 is never addressed by a sequence; it repeats A so the table is a full 16 entries.
    localparam digit_t CODE_TABLE [SEQ_LEN_MAX+1] = '{
        4'hA, 4'hA, 4'hC, 4'h0, 4'hF, 4'hF, 4'hE, 4'hA,
        4'h1, 4'h5, 4'hA, 4'h9, 4'h0, 4'h0, 4'hD, 4'hA
    };

    function automatic digit_t code_digit(input logic [3:0] index);
        return CODE_TABLE[index];
    endfunction

endpackage

// File: rtl/code_sequence_checker_if.sv
// Digit valid/ready handshake between a digit source and the sequence checker.
interface code_sequence_checker_if;
    import code_pkg::*;

    digit_t digit_in;
    logic   digit_valid;
    logic   digit_ready;

    modport master (
        output digit_in,
        output digit_valid,
        input  digit_ready
    );

    modport slave (
        input  digit_in,
        input  digit_valid,
        output digit_ready
    );

endinterface

// File: rtl/code_rom.sv
// Combinational code table lookup, addressed by the current match position.
module code_rom
    import code_pkg::*;
(
    input  logic [3:0] index,
    output digit_t     digit
);

    assign digit = code_digit(index);

endmodule

// File: rtl/code_sequence_checker.sv
// Checks an incoming hex digit stream against the fixed code sequence and reports
// match/done/error/timeout status, the match position and a saturating fail count.
module code_sequence_checker
    import code_pkg::*;
#(
    parameter int SEQ_LEN        = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    code_sequence_checker_if.slave  digit_if,
    input  logic                    clear,
    output logic                    match,
    output logic                    done,
    output logic                    error,
    output logic                    timeout,
    output logic [3:0]              position,
    output logic [7:0]              fail_count
);

    localparam int         TIMER_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_POS    = 4'(SEQ_LEN - 1);
    localparam logic [3:0] FULL_POS    = 4'(SEQ_LEN);

    state_t               state_q, state_d;
    logic [3:0]           position_q, position_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 match_q, match_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           fail_count_q, fail_count_d;

    digit_t               expected_digit;
    logic                 ready;
    logic                 transfer;
    logic                 digit_ok;
    logic                 enter_fail;
    logic                 fail_by_timeout;

    code_rom u_code_rom (
        .index (position_q),
        .digit (expected_digit)
    );

    assign ready                = (state_q == ST_IDLE) || (state_q == ST_CHECK);
    assign digit_if.digit_ready = ready;
    assign transfer             = digit_if.digit_valid && ready;
    assign digit_ok             = (digit_if.digit_in == expected_digit);

    always_comb begin
        state_d         = state_q;
        position_d      = position_q;
        timer_d         = timer_q;
        match_d         = 1'b0;
        done_d          = done_q;
        error_d         = error_q;
        timeout_d       = timeout_q;
        fail_count_d    = fail_count_q;
        enter_fail      = 1'b0;
        fail_by_timeout = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            position_d = 4'd0;
            timer_d    = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (transfer) begin
                        if (digit_ok) begin
                            position_d = 4'd1;
                            timer_d    = '0;
                            if (SEQ_LEN == 1) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                match_d = 1'b1;
                            end else begin
                                state_d = ST_CHECK;
                            end
                        end else begin
                            enter_fail = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (transfer) begin
                        if (!digit_ok) begin
                            enter_fail = 1'b1;
                        end else if (position_q == LAST_POS) begin
                            state_d    = ST_DONE;
                            position_d = FULL_POS;
                            done_d     = 1'b1;
                            match_d    = 1'b1;
                            timer_d    = '0;
                        end else begin
                            position_d = position_q + 4'd1;
                            timer_d    = '0;
                        end
                    end else if (timer_q == TIMER_LIMIT) begin
                        enter_fail      = 1'b1;
                        fail_by_timeout = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Position is deliberately left untouched so the failing index stays visible.
        if (enter_fail) begin
            state_d   = ST_FAIL;
            error_d   = 1'b1;
            timeout_d = fail_by_timeout;
            timer_d   = '0;
            if (fail_count_q != 8'hFF) begin
                fail_count_d = fail_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            position_q   <= 4'd0;
            timer_q      <= '0;
            match_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            fail_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            position_q   <= position_d;
            timer_q      <= timer_d;
            match_q      <= match_d;
            done_q       <= done_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign match      = match_q;
    assign done       = done_q;
    assign error      = error_q;
    assign timeout    = timeout_q;
    assign position   = position_q;
    assign fail_count = fail_count_q;

endmodule
